// File: rtl/aes_gf_pkg.sv
// aes_gf_pkg -- shared GF(2^8) helpers and types for the AES MixColumns datapath.
//
// Contents:
//   byte_t          8-bit GF(2^8) element
//   column_t        one AES state column; element i is row i
//   mixcol_state_e  engine FSM states {ACC, HOLD}
//   FWD_COEF        first row of the MixColumns matrix
//   INV_COEF        first row of the InvMixColumns matrix
//   xtime()         multiply by x (0x02), modulo 0x11B
//   gf_mul_const()  multiply by a small constant (bits 3:0 only)
//
// Optional feature used by the top: MIXCOL_BYPASS_EN (final-round pass-through).
package aes_gf_pkg;

    typedef logic [7:0] byte_t;
    typedef byte_t [3:0] column_t;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } mixcol_state_e;

    // Row i of either matrix is this row rotated right by i, so the
    // coefficient applied to byte j for row i is COEF[(j - i) mod 4].
    localparam byte_t FWD_COEF [4] = '{8'h02, 8'h03, 8'h01, 8'h01};
    localparam byte_t INV_COEF [4] = '{8'h0E, 8'h0B, 8'h0D, 8'h09};

    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // Every MixColumns coefficient fits in four bits, so only x1/x2/x4/x8
    // terms are needed. Bits 7:4 of coeff are ignored.
    function automatic byte_t gf_mul_const(input byte_t b, input byte_t coeff);
        byte_t x2;
        byte_t x4;
        byte_t x8;
        byte_t r;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        r  = 8'h00;
        if (coeff[0]) r = r ^ b;
        if (coeff[1]) r = r ^ x2;
        if (coeff[2]) r = r ^ x4;
        if (coeff[3]) r = r ^ x8;
        return r;
    endfunction

endpackage

// File: rtl/gf_mul_row.sv
// gf_mul_row -- combinational contribution of one column byte to all four
// mixed output rows.
//
// Ports:
//   b     in   8   column byte b_col
//   inv   in   1   0 = MixColumns coefficients, 1 = InvMixColumns
//   col   in   2   position of b within the column (row index 0..3)
//   prod  out  32  prod[i] = M[i][(col - i) mod 4] * b
module gf_mul_row
    import aes_gf_pkg::*;
(
    input  byte_t      b,
    input  logic       inv,
    input  logic [1:0] col,
    output column_t    prod
);

    always_comb begin
        prod = '0;
        for (int i = 0; i < 4; i++) begin
            // 2-bit subtraction gives the (col - i) mod 4 rotation for free.
            prod[i] = gf_mul_const(b, inv ? INV_COEF[col - 2'(i)]
                                          : FWD_COEF[col - 2'(i)]);
        end
    end

endmodule

// File: rtl/mixcol_stream.sv
// mixcol_stream -- streaming AES MixColumns / InvMixColumns engine.
//
// A 4-byte column arrives as BEATS = 4/LANES beats of LANES bytes (row 0
// first). Each accepted beat XORs its partial products into four byte
// accumulators; after the last beat the mixed column is presented on the
// output until it is taken.
//
// Parameters:
//   LANES      bytes per input beat: 1, 2 or 4
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   in_valid   input beat valid
//   in_ready   engine can accept a beat
//   in_data    8*LANES bits; byte k of beat t is column byte b[t*LANES+k]
//   in_inv     0 = MixColumns, 1 = InvMixColumns (first beat only)
//   in_bypass  pass the column through unmixed (first beat only);
//              present only when MIXCOL_BYPASS_EN is defined
//   out_valid  mixed column available
//   out_ready  downstream accepts the column
//   out_data   out_data[8*i+7:8*i] = mixed row byte r_i
//   out_col    index of out_data's column within the state, 0..3
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in ACC (and not in reset); a beat offered
// while in_ready is low is not taken, so upstream must hold it. out_valid is
// high only in HOLD, during which out_data/out_col do not change; it never
// depends on out_ready.
module mixcol_stream
    import aes_gf_pkg::*;
#(
    parameter int LANES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*LANES-1:0] in_data,
    input  logic               in_inv,
`ifdef MIXCOL_BYPASS_EN
    input  logic               in_bypass,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_data,
    output logic [1:0]         out_col
);

    localparam int         BEATS     = 4 / LANES;
    localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

    mixcol_state_e state;
    mixcol_state_e state_next;

    logic [1:0] beat_cnt;
    column_t    acc;
    column_t    acc_next;
    column_t    beat_sum;
    logic       inv_q;
    logic       inv_eff;
    logic       byp_eff;
    logic       first_beat;
    logic       beat_acc;
    logic       out_hs;

    column_t    lane_prod [LANES];
    logic [1:0] lane_col  [LANES];

    assign in_ready   = (state == ACC) && !rst;
    assign out_valid  = (state == HOLD);
    assign out_data   = acc;
    assign beat_acc   = in_valid && in_ready;
    assign out_hs     = out_valid && out_ready;
    assign first_beat = (beat_cnt == 2'd0);

    // Mode is taken live on the first beat and from the latch afterwards,
    // so later beats cannot change how the column is mixed.
    assign inv_eff = first_beat ? in_inv : inv_q;

`ifdef MIXCOL_BYPASS_EN
    logic byp_q;
    assign byp_eff = first_beat ? in_bypass : byp_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            byp_q <= 1'b0;
        end else if (beat_acc && first_beat) begin
            byp_q <= in_bypass;
        end
    end
`else
    assign byp_eff = 1'b0;
`endif

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign lane_col[k] = 2'(int'(beat_cnt) * LANES + k);

        gf_mul_row u_row (
            .b    (in_data[8*k +: 8]),
            .inv  (inv_eff),
            .col  (lane_col[k]),
            .prod (lane_prod[k])
        );
    end

    // Combine this beat's lanes; bypass drops each byte into its own row.
    always_comb begin
        beat_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            if (byp_eff) begin
                beat_sum[lane_col[k]] = beat_sum[lane_col[k]] ^ in_data[8*k +: 8];
            end else begin
                beat_sum = beat_sum ^ lane_prod[k];
            end
        end
        // The first beat overwrites so no clear cycle is needed between columns.
        acc_next = first_beat ? beat_sum : (acc ^ beat_sum);
    end

    always_comb begin
        state_next = state;
        case (state)
            ACC:     if (beat_acc && (beat_cnt == LAST_BEAT)) state_next = HOLD;
            HOLD:    if (out_ready) state_next = ACC;
            default: state_next = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ACC;
            beat_cnt <= 2'd0;
            acc      <= '0;
            inv_q    <= 1'b0;
            out_col  <= 2'd0;
        end else begin
            state <= state_next;
            if (beat_acc) begin
                acc      <= acc_next;
                beat_cnt <= (beat_cnt == LAST_BEAT) ? 2'd0 : 2'(beat_cnt + 2'd1);
                if (first_beat) inv_q <= in_inv;
            end
            if (out_hs) out_col <= 2'(out_col + 2'd1);
        end
    end

endmodule

// File: tb/tb_mixcol_stream.sv
// tb_mixcol_stream -- bench for mixcol_stream with three instances
// (LANES = 1, 2, 4). Expected columns come from a matrix-times-vector model
// over GF(2^8) written directly from the MixColumns definition.
// Define MIXCOL_BYPASS_EN to also exercise the pass-through feature.
module tb_mixcol_stream;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        in_valid  [3];
    logic        in_ready  [3];
    logic [31:0] in_data   [3];
    logic        in_inv    [3];
`ifdef MIXCOL_BYPASS_EN
    logic        in_bypass [3];
`endif
    logic        out_valid [3];
    logic        out_ready [3];
    logic [31:0] out_data  [3];
    logic [1:0]  out_col   [3];

    int checks = 0;
    int errors = 0;
    int col_cnt [3];
    logic [33:0] exp_q[$];

    for (genvar d = 0; d < 3; d++) begin : g_dut
        localparam int L = (d == 0) ? 1 : (d == 1) ? 2 : 4;
        mixcol_stream #(.LANES(L)) dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[d]),
            .in_ready  (in_ready[d]),
            .in_data   (in_data[d][8*L-1:0]),
            .in_inv    (in_inv[d]),
`ifdef MIXCOL_BYPASS_EN
            .in_bypass (in_bypass[d]),
`endif
            .out_valid (out_valid[d]),
            .out_ready (out_ready[d]),
            .out_data  (out_data[d]),
            .out_col   (out_col[d])
        );
    end

    function automatic int lanes(input int d);
        return (d == 0) ? 1 : (d == 1) ? 2 : 4;
    endfunction

    // Shift-and-add multiply modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        int x;
        int y;
        int p;
        x = a; y = b; p = 0;
        for (int n = 0; n < 8; n++) begin
            if (y & 1) p = p ^ x;
            y = y >> 1;
            x = x << 1;
            if (x & 'h100) x = x ^ 'h11B;
        end
        return 8'(p);
    endfunction

    function automatic logic [31:0] model(input logic [31:0] col, input logic inv, input logic byp);
        logic [7:0]  base [4];
        logic [7:0]  r;
        logic [31:0] res;
        if (byp) return col;
        if (inv) base = '{8'h0E, 8'h0B, 8'h0D, 8'h09};
        else     base = '{8'h02, 8'h03, 8'h01, 8'h01};
        res = '0;
        for (int i = 0; i < 4; i++) begin
            r = 8'h00;
            for (int j = 0; j < 4; j++) r = r ^ gmul(base[(j - i + 4) % 4], col[8*j +: 8]);
            res[8*i +: 8] = r;
        end
        return res;
    endfunction

    // Offers nb beats of a column (0 = the whole column); later beats carry a
    // flipped or random mode to confirm it is ignored.
    task automatic drive_col(input int d, input logic [31:0] col, input logic inv,
                             input logic byp, input bit gaps, input bit flip, input int nb);
        int l;
        int n;
        int beats;
        l = lanes(d);
        beats = (nb == 0) ? 4 / l : nb;
        for (int t = 0; t < beats; t++) begin
            if (gaps) begin
                n = $urandom_range(0, 2);
                repeat (n) begin
                    in_valid[d] = 1'b0;
                    in_data[d]  = $urandom;
                    in_inv[d]   = 1'($urandom_range(0, 1));
                    @(negedge clk);
                end
            end
            in_valid[d] = 1'b1;
            in_data[d]  = $urandom;
            for (int k = 0; k < l; k++) in_data[d][8*k +: 8] = col[8*(t*l + k) +: 8];
            if (t == 0) in_inv[d] = inv;
            else        in_inv[d] = flip ? ~inv : 1'($urandom_range(0, 1));
`ifdef MIXCOL_BYPASS_EN
            if (t == 0) in_bypass[d] = byp;
            else        in_bypass[d] = flip ? ~byp : 1'($urandom_range(0, 1));
`endif
            n = 0;
            while (in_ready[d] !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (in_ready[d] !== 1'b1) begin
                checks++; errors++;
                $display("FAIL drive_ready dut%0d beat %0d: in_ready=%b required 1", d, t, in_ready[d]);
            end
            @(negedge clk);
        end
        in_valid[d] = 1'b0;
    endtask

    // Checks the presented column against the scoreboard, optionally holds it
    // under backpressure, then takes it.
    task automatic check_out(input int d, input int hold, input bit chk_lat);
        logic [33:0] e;
        if (chk_lat) begin
            checks++;
            if (out_valid[d] !== 1'b1) begin
                errors++;
                $display("FAIL latency dut%0d: out_valid=%b required 1", d, out_valid[d]);
            end
        end
        e = exp_q.pop_front();
        checks++;
        if (out_data[d] !== e[31:0]) begin
            errors++;
            $display("FAIL out_data dut%0d: got %h required %h", d, out_data[d], e[31:0]);
        end
        checks++;
        if (out_col[d] !== e[33:32]) begin
            errors++;
            $display("FAIL out_col dut%0d: got %0d required %0d", d, out_col[d], e[33:32]);
        end
        repeat (hold) @(negedge clk);
        if (hold > 0) begin
            checks++;
            if (out_valid[d] !== 1'b1 || out_data[d] !== e[31:0]) begin
                errors++;
                $display("FAIL hold_stable dut%0d: valid=%b data=%h required 1 %h",
                         d, out_valid[d], out_data[d], e[31:0]);
            end
        end
        out_ready[d] = 1'b1;
        @(negedge clk);
        out_ready[d] = 1'b0;
        col_cnt[d] = (col_cnt[d] + 1) % 4;
        checks++;
        if (out_valid[d] !== 1'b0 || in_ready[d] !== 1'b1) begin
            errors++;
            $display("FAIL post_handshake dut%0d: out_valid=%b in_ready=%b required 0 1",
                     d, out_valid[d], in_ready[d]);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            in_valid[d] = 1'b0;
            out_ready[d] = 1'b0;
            col_cnt[d] = 0;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin
            in_data[d] = '0;
            in_inv[d] = 1'b0;
`ifdef MIXCOL_BYPASS_EN
            in_bypass[d] = 1'b0;
`endif
        end
        apply_reset();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (in_ready[d] !== 1'b0 || out_valid[d] !== 1'b0 ||
                out_data[d] !== 32'h0 || out_col[d] !== 2'd0) begin
                errors++;
                $display("FAIL reset_state dut%0d: rdy=%b vld=%b data=%h col=%0d required 0 0 0 0",
                         d, in_ready[d], out_valid[d], out_data[d], out_col[d]);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (in_ready[d] !== 1'b1) begin
                errors++;
                $display("FAIL reset_release dut%0d: in_ready=%b required 1", d, in_ready[d]);
            end
        end
    endtask

    task automatic test_vectors();
        exp_q.push_back({2'(col_cnt[0]), 32'hbca14d8e});
        drive_col(0, 32'h455313db, 1'b0, 1'b0, 0, 0, 0);
        check_out(0, 0, 1);
        exp_q.push_back({2'(col_cnt[2]), 32'h455313db});
        drive_col(2, 32'hbca14d8e, 1'b1, 1'b0, 0, 0, 0);
        check_out(2, 0, 1);
        exp_q.push_back({2'(col_cnt[2]), 32'h9d58dc9f});
        drive_col(2, 32'h5c220af2, 1'b0, 1'b0, 0, 0, 0);
        check_out(2, 0, 1);
        for (int m = 0; m < 2; m++) begin
            exp_q.push_back({2'(col_cnt[2]), 32'hc6c6c6c6});
            drive_col(2, 32'hc6c6c6c6, 1'(m), 1'b0, 0, 0, 0);
            check_out(2, 0, 1);
        end
    endtask

    task automatic test_mode_latch();
        logic [31:0] col;
        for (int c = 0; c < 6; c++) begin
            col = $urandom;
            exp_q.push_back({2'(col_cnt[1]), model(col, 1'(c == 5), 1'b0)});
            drive_col(1, col, 1'(c == 5), 1'b0, 0, 1, 0);
            check_out(1, 0, 1);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] col;
        logic [31:0] e;
        col = $urandom;
        e = model(col, 1'b0, 1'b0);
        exp_q.push_back({2'(col_cnt[0]), e});
        drive_col(0, col, 1'b0, 1'b0, 0, 0, 0);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (in_ready[0] !== 1'b0 || out_valid[0] !== 1'b1 || out_data[0] !== e) begin
                errors++;
                $display("FAIL backpressure cyc %0d: rdy=%b vld=%b data=%h required 0 1 %h",
                         c, in_ready[0], out_valid[0], out_data[0], e);
            end
            in_valid[0] = 1'b1;
            in_data[0] = $urandom;
            in_inv[0] = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        in_valid[0] = 1'b0;
        check_out(0, 0, 0);
        // The ignored beats must not have advanced the beat count.
        col = $urandom;
        exp_q.push_back({2'(col_cnt[0]), model(col, 1'b1, 1'b0)});
        drive_col(0, col, 1'b1, 1'b0, 0, 0, 0);
        check_out(0, 0, 1);
    endtask

    task automatic test_reset_mid();
        drive_col(0, $urandom, 1'b0, 1'b0, 0, 0, 2);
        apply_reset();
        rst = 1'b0;
        checks++;
        for (int c = 0; c < 6; c++) begin
            if (out_valid[0] !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_valid cyc %0d: out_valid=%b required 0", c, out_valid[0]);
                break;
            end
            @(negedge clk);
        end
        exp_q.push_back({2'(col_cnt[0]), 32'hbca14d8e});
        drive_col(0, 32'h455313db, 1'b0, 1'b0, 0, 0, 0);
        check_out(0, 0, 1);
    endtask

    task automatic test_back_to_back();
        int t_prev;
        int l;
        logic [31:0] col;
        logic inv;
        for (int d = 0; d < 3; d++) begin
            l = lanes(d);
            t_prev = -1;
            for (int c = 0; c < 6; c++) begin
                col = $urandom;
                inv = 1'($urandom_range(0, 1));
                exp_q.push_back({2'(col_cnt[d]), model(col, inv, 1'b0)});
                drive_col(d, col, inv, 1'b0, 0, 0, 0);
                if (t_prev >= 0) begin
                    checks++;
                    if (cyc - t_prev !== 4 / l + 1) begin
                        errors++;
                        $display("FAIL throughput dut%0d: period %0d required %0d", d, cyc - t_prev, 4 / l + 1);
                    end
                end
                t_prev = cyc;
                check_out(d, 0, 1);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] col;
        logic inv;
        logic byp;
        for (int n = 0; n < 45; n++) begin
            int d;
            d = $urandom_range(0, 2);
            col = $urandom;
            inv = 1'($urandom_range(0, 1));
            byp = 1'b0;
`ifdef MIXCOL_BYPASS_EN
            byp = 1'($urandom_range(0, 3) == 0);
`endif
            exp_q.push_back({2'(col_cnt[d]), model(col, inv, byp)});
            drive_col(d, col, inv, byp, 1, 0, 0);
            check_out(d, $urandom_range(0, 3), 1);
        end
    endtask

`ifdef MIXCOL_BYPASS_EN
    task automatic test_bypass();
        for (int d = 0; d < 3; d++) begin
            exp_q.push_back({2'(col_cnt[d]), 32'h455313db});
            drive_col(d, 32'h455313db, 1'($urandom_range(0, 1)), 1'b1, 0, 1, 0);
            check_out(d, 0, 1);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_vectors();
        test_mode_latch();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
`ifdef MIXCOL_BYPASS_EN
        test_bypass();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
